game_tick_ctrl: RTL

Parametrised game sequencer that owns the run/pause/life/level state of the snake game and issues game ticks to the snake datapath. Ticks come from either an external phase toggle or an internal divider whose period shrinks with level. It also keeps score, lives and the latched failure/success flags. It sits between the input controller and the snake/apple/vga instances in the game top level.

---
 rtl/game_pkg.sv | 18 +
 rtl/game_tick_ctrl_divider.sv | 67 ++++++
 rtl/game_tick_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the snake game sequencer (game_tick_ctrl).
// The pause feature in game_tick_ctrl is enabled by defining SNAKE_PAUSE_EN.
package game_pkg;

    // Encodings are visible on o_state, so they are fixed explicitly.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DEAD  = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } game_state_t;

    localparam int LIVES_W = 3;
    localparam int LEVEL_W = 3;

endpackage

// File: rtl/game_tick_ctrl_divider.sv
// tick_divider: loadable down-counter that produces the internal game tick.
// The reload period shrinks with level and is floored at MIN_PERIOD.
module tick_divider
    import game_pkg::*;
#(
    parameter int               DIV_W       = 24,
    parameter logic [DIV_W-1:0] BASE_PERIOD = 24'd6_000_000,
    parameter logic [DIV_W-1:0] PERIOD_STEP = 24'd500_000,
    parameter logic [DIV_W-1:0] MIN_PERIOD  = 24'd1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic               en,
    input  logic [LEVEL_W-1:0] level,
    output logic               zero
);

    // Three extra bits hold level*PERIOD_STEP for any 3-bit level without overflow.
    localparam int CALC_W = DIV_W + 3;

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] reload_val;

    // max(BASE_PERIOD - lvl*PERIOD_STEP, MIN_PERIOD) without wrapping below zero.
    function automatic logic [DIV_W-1:0] period_of(input logic [LEVEL_W-1:0] lvl);
        logic [CALC_W-1:0] base_c;
        logic [CALC_W-1:0] min_c;
        logic [CALC_W-1:0] step_c;
        logic [CALC_W-1:0] diff_c;
        base_c = CALC_W'(BASE_PERIOD);
        min_c  = CALC_W'(MIN_PERIOD);
        step_c = CALC_W'(lvl) * CALC_W'(PERIOD_STEP);
        if (step_c >= base_c) begin
            return MIN_PERIOD;
        end
        diff_c = base_c - step_c;
        return (diff_c > min_c) ? DIV_W'(diff_c) : MIN_PERIOD;
    endfunction

    // Reload value for the current level; takes effect only when the counter reloads.
    always_comb begin
        reload_val = period_of(level) - DIV_W'(1);
    end

    assign zero = en && (count == '0);

    // Down-counter: clear to the level-0 period, explicit load, or count with auto-reload.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            count <= BASE_PERIOD - DIV_W'(1);
        end else if (clear) begin
            count <= BASE_PERIOD - DIV_W'(1);
        end else if (load) begin
            count <= reload_val;
        end else if (en) begin
            if (count == '0) begin
                count <= reload_val;
            end else begin
                count <= count - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/game_tick_ctrl.sv
// game_tick_ctrl: run/pause/life/level sequencer for the snake game.
// Issues game ticks from either an external phase toggle or the internal
// divider, keeps score, lives and the sticky failure/success flags.
// Optional: define SNAKE_PAUSE_EN to let rising edges of i_pause toggle RUN<->PAUSE.
module game_tick_ctrl
    import game_pkg::*;
#(
    parameter int               DIV_W            = 24,
    parameter logic [DIV_W-1:0] BASE_PERIOD      = 24'd6_000_000,
    parameter logic [DIV_W-1:0] PERIOD_STEP      = 24'd500_000,
    parameter logic [DIV_W-1:0] MIN_PERIOD       = 24'd1_000_000,
    parameter int               MAX_LEVEL        = 7,
    parameter int               APPLES_PER_LEVEL = 4,
    parameter int               LIVES            = 3,
    parameter int               SCORE_W          = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_restart,
    input  logic               i_start,
    input  logic               i_ext_phase,
    input  logic               i_phase,
    input  logic               i_pause,
    input  logic               i_ready,
    input  logic               i_tick_ack,
    input  logic               i_failure,
    input  logic               i_success,
    input  logic               i_eat,
    output logic               o_tick,
    output logic [2:0]         o_state,
    output logic [LEVEL_W-1:0] o_level,
    output logic [LIVES_W-1:0] o_lives,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_round_rst,
    output logic               o_failure,
    output logic               o_success
);

    localparam int EAT_W = $clog2(APPLES_PER_LEVEL + 1);

    game_state_t        state;
    game_state_t        state_nx;
    logic               in_run;
    logic               round_go;
    logic               life_lost;
    logic               pause_rise;
    logic               div_zero;
    logic               tick_req;
    logic               phase_ref;
    logic               tick_q;
    logic               round_rst_q;
    logic               failure_q;
    logic               success_q;
    logic [LEVEL_W-1:0] level_q;
    logic [LIVES_W-1:0] lives_q;
    logic [SCORE_W-1:0] score_q;
    logic [EAT_W-1:0]   eat_cnt;

    assign in_run = (state == ST_RUN);

`ifdef SNAKE_PAUSE_EN
    logic pause_q;

    // Registered copy of i_pause for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= i_pause;
        end
    end

    assign pause_rise = i_pause & ~pause_q;
`else
    logic unused_pause;
    assign unused_pause = i_pause;
    assign pause_rise   = 1'b0;
`endif

    // Internal tick source; counts only while running in divider mode, so PAUSE holds it.
    tick_divider #(
        .DIV_W      (DIV_W),
        .BASE_PERIOD(BASE_PERIOD),
        .PERIOD_STEP(PERIOD_STEP),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_divider (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(i_restart),
        .load (round_go),
        .en   (in_run && !i_ext_phase),
        .level(level_q),
        .zero (div_zero)
    );

    // A phase edge is measured against phase_ref, which follows i_phase every cycle.
    assign tick_req = in_run && (i_ext_phase ? (i_phase != phase_ref) : div_zero);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; success beats failure, both beat a pause request.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nx  = state;
        round_go  = 1'b0;
        life_lost = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (i_success) begin
                    state_nx = ST_WIN;
                end else if (i_failure) begin
                    life_lost = 1'b1;
                    state_nx  = (lives_q <= LIVES_W'(1)) ? ST_OVER : ST_DEAD;
                end else if (pause_rise) begin
                    state_nx = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_rise) state_nx = ST_RUN;
            end
            ST_DEAD: begin
                if (i_start) begin
                    state_nx = ST_RUN;
                    round_go = 1'b1;
                end
            end
            ST_OVER, ST_WIN: begin
                state_nx = state;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        if (i_restart) begin
            state_nx  = ST_IDLE;
            round_go  = 1'b0;
            life_lost = 1'b0;
        end
    end

    // Tick grant, lives, score/level and sticky result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // i_phase is not a constant, so async reset uses 0; it is resynced within a cycle.
            phase_ref   <= 1'b0;
            tick_q      <= 1'b0;
            round_rst_q <= 1'b0;
            failure_q   <= 1'b0;
            success_q   <= 1'b0;
            level_q     <= '0;
            lives_q     <= LIVES_W'(LIVES);
            score_q     <= '0;
            eat_cnt     <= '0;
        end else if (i_restart) begin
            phase_ref   <= i_phase;
            tick_q      <= 1'b0;
            round_rst_q <= 1'b0;
            failure_q   <= 1'b0;
            success_q   <= 1'b0;
            level_q     <= '0;
            lives_q     <= LIVES_W'(LIVES);
            score_q     <= '0;
            eat_cnt     <= '0;
        end else begin
            // Tracking every cycle both consumes the edge in RUN and avoids stale edges elsewhere.
            phase_ref   <= i_phase;
            round_rst_q <= round_go;

            // Ungranted requests are dropped, never queued; ack wins over a new request.
            if (!in_run || state_nx != ST_RUN) begin
                tick_q <= 1'b0;
            end else if (i_tick_ack) begin
                tick_q <= 1'b0;
            end else if (tick_req && i_ready && !tick_q) begin
                tick_q <= 1'b1;
            end

            if (life_lost) begin
                lives_q <= lives_q - LIVES_W'(1);
            end
            if (in_run && state_nx == ST_OVER) failure_q <= 1'b1;
            if (in_run && state_nx == ST_WIN)  success_q <= 1'b1;

            if (in_run && i_eat) begin
                if (score_q != '1) begin
                    score_q <= score_q + SCORE_W'(1);
                end
                if (eat_cnt == EAT_W'(APPLES_PER_LEVEL - 1)) begin
                    eat_cnt <= '0;
                    if (level_q < LEVEL_W'(MAX_LEVEL)) begin
                        level_q <= level_q + LEVEL_W'(1);
                    end
                end else begin
                    eat_cnt <= eat_cnt + EAT_W'(1);
                end
            end
        end
    end

    assign o_tick      = tick_q;
    assign o_state     = state;
    assign o_level     = level_q;
    assign o_lives     = lives_q;
    assign o_score     = score_q;
    assign o_round_rst = round_rst_q;
    assign o_failure   = failure_q;
    assign o_success   = success_q;

endmodule
